// File: rtl/arrow_hit_judge.sv
// rtl/arrow_hit_judge.sv - in-flight arrow queue with per-player hit/miss judging
module arrow_hit_judge #(
    parameter int TICK_DIV = 500000,
    parameter int TRAVEL   = 100,
    parameter int WINDOW   = 5,
    parameter int DEPTH    = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     game_active,
    input  logic                     pattern_valid,
    input  logic [7:0]               pattern_out,
    input  logic [3:0]               player_a_keys,
    input  logic [3:0]               player_b_keys,
    output logic                     perfect_hit_a,
    output logic                     perfect_hit_b,
    output logic                     miss_a,
    output logic                     miss_b,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     overflow
);

    localparam int PW     = $clog2(DEPTH);
    localparam int EXPIRE = TRAVEL + WINDOW + 1;
    localparam int AW     = $clog2(EXPIRE + 1);
    localparam int WIN_LO = TRAVEL - WINDOW;
    localparam int WIN_HI = TRAVEL + WINDOW;
    localparam int PRW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRW-1:0] PRESC_LAST = PRW'(TICK_DIV - 1);
    localparam logic [AW-1:0]  AGE_EXPIRE = AW'(EXPIRE);
    localparam logic [PW:0]    COUNT_FULL = (PW + 1)'(DEPTH);

    // Reserved pattern bits carry no meaning here.
    logic unused_pattern_bits;
    assign unused_pattern_bits = ^pattern_out[7:4];

    // Registered state
    logic [PRW-1:0]   presc_q, presc_d;
    logic [3:0]       keys_a_q, keys_a_d;
    logic [3:0]       keys_b_q, keys_b_d;
    logic [3:0]       mask_q [DEPTH];
    logic [3:0]       mask_d [DEPTH];
    logic [AW-1:0]    age_q  [DEPTH];
    logic [AW-1:0]    age_d  [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] a_done_q, a_done_d;
    logic [DEPTH-1:0] b_done_q, b_done_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             hit_a_q, hit_a_d;
    logic             hit_b_q, hit_b_d;
    logic             miss_a_q, miss_a_d;
    logic             miss_b_q, miss_b_d;

    // Combinational decode of the head entry and this cycle's events
    logic             tick;
    logic [3:0]       edge_a, edge_b;
    logic             head_valid;
    logic [3:0]       head_mask;
    logic [AW-1:0]    head_age;
    logic             head_a_done, head_b_done;
    logic             in_window;
    logic             hit_a, hit_b;
    logic             pop_both, pop_expire, pop;
    logic             push_req, push_ok;

    // Head decode, tick generation and hit/retire decisions on pre-tick state
    always_comb begin
        tick        = game_active && (presc_q == PRESC_LAST);
        edge_a      = player_a_keys & ~keys_a_q;
        edge_b      = player_b_keys & ~keys_b_q;
        head_valid  = valid_q[head_q];
        head_mask   = mask_q[head_q];
        head_age    = age_q[head_q];
        head_a_done = a_done_q[head_q];
        head_b_done = b_done_q[head_q];
        in_window   = (int'(head_age) >= WIN_LO) && (int'(head_age) <= WIN_HI);

        hit_a = game_active && head_valid && !head_a_done && in_window &&
                (edge_a != 4'b0) && ((edge_a & ~head_mask) == 4'b0) &&
                ((edge_a & head_mask) != 4'b0);
        hit_b = game_active && head_valid && !head_b_done && in_window &&
                (edge_b != 4'b0) && ((edge_b & ~head_mask) == 4'b0) &&
                ((edge_b & head_mask) != 4'b0);

        pop_both   = game_active && head_valid && head_a_done && head_b_done;
        pop_expire = game_active && head_valid && (head_age == AGE_EXPIRE);
        pop        = pop_both || pop_expire;

        push_req = game_active && pattern_valid && (pattern_out[3:0] != 4'b0);
        push_ok  = push_req && ((count_q != COUNT_FULL) || pop);
    end

    // Next-state for prescaler, key history and registered pulses
    always_comb begin
        presc_d = presc_q;
        if (game_active) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        keys_a_d = player_a_keys;
        keys_b_d = player_b_keys;
        hit_a_d  = hit_a;
        hit_b_d  = hit_b;
        // A both-done head never raises a miss, even if it has also expired.
        miss_a_d = pop_expire && !pop_both && !head_a_done;
        miss_b_d = pop_expire && !pop_both && !head_b_done;
    end

    // Next-state for the arrow queue: age, mark done, pop, push
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mask_d[i] = mask_q[i];
            age_d[i]  = age_q[i];
        end
        valid_d    = valid_q;
        a_done_d   = a_done_q;
        b_done_d   = b_done_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (tick) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (age_q[i] != AGE_EXPIRE)) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end

        if (hit_a) begin
            a_done_d[head_q] = 1'b1;
        end
        if (hit_b) begin
            b_done_d[head_q] = 1'b1;
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        // Written after the pop so a push into the slot just freed wins.
        if (push_ok) begin
            mask_d[tail_q]   = pattern_out[3:0];
            age_d[tail_q]    = '0;
            valid_d[tail_q]  = 1'b1;
            a_done_d[tail_q] = 1'b0;
            b_done_d[tail_q] = 1'b0;
            tail_d           = tail_q + 1'b1;
        end

        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            presc_q    <= '0;
            keys_a_q   <= '0;
            keys_b_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
                age_q[i]  <= '0;
            end
            valid_q    <= '0;
            a_done_q   <= '0;
            b_done_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            hit_a_q    <= 1'b0;
            hit_b_q    <= 1'b0;
            miss_a_q   <= 1'b0;
            miss_b_q   <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            keys_a_q   <= keys_a_d;
            keys_b_q   <= keys_b_d;
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= mask_d[i];
                age_q[i]  <= age_d[i];
            end
            valid_q    <= valid_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            hit_a_q    <= hit_a_d;
            hit_b_q    <= hit_b_d;
            miss_a_q   <= miss_a_d;
            miss_b_q   <= miss_b_d;
        end
    end

    assign perfect_hit_a = hit_a_q;
    assign perfect_hit_b = hit_b_q;
    assign miss_a        = miss_a_q;
    assign miss_b        = miss_b_q;
    assign queue_count   = count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_arrow_hit_judge.sv
// tb/tb_arrow_hit_judge.sv - directed and random checks of arrow_hit_judge against a queue model
module tb_arrow_hit_judge;

    localparam int TICK_DIV = 4;
    localparam int TRAVEL   = 10;
    localparam int WINDOW   = 2;
    localparam int DEPTH    = 4;
    localparam int EXPIRE   = TRAVEL + WINDOW + 1;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       game_active = 1'b0;
    logic       pattern_valid = 1'b0;
    logic [7:0] pattern_out = 8'h00;
    logic [3:0] player_a_keys = 4'h0;
    logic [3:0] player_b_keys = 4'h0;
    logic       perfect_hit_a, perfect_hit_b, miss_a, miss_b, overflow;
    logic [2:0] queue_count;

    arrow_hit_judge #(
        .TICK_DIV(TICK_DIV), .TRAVEL(TRAVEL), .WINDOW(WINDOW), .DEPTH(DEPTH)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .game_active(game_active),
        .pattern_valid(pattern_valid), .pattern_out(pattern_out),
        .player_a_keys(player_a_keys), .player_b_keys(player_b_keys),
        .perfect_hit_a(perfect_hit_a), .perfect_hit_b(perfect_hit_b),
        .miss_a(miss_a), .miss_b(miss_b),
        .queue_count(queue_count), .overflow(overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] mask;
        int         age;
        bit         ad;
        bit         bd;
    } arrow_t;

    arrow_t     mq[$];
    int         m_presc;
    logic [3:0] m_kpa, m_kpb;
    bit         m_ovf;
    bit         e_ha, e_hb, e_ma, e_mb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_presc = 0;
        m_kpa = 4'h0;
        m_kpb = 4'h0;
        m_ovf = 1'b0;
        e_ha = 0; e_hb = 0; e_ma = 0; e_mb = 0;
    endtask

    task automatic model_step();
        bit         tick;
        bit         pop;
        bit         inwin;
        int         n_before;
        logic [3:0] ea, eb;
        arrow_t     na;
        e_ha = 0; e_hb = 0; e_ma = 0; e_mb = 0;
        if (game_active) begin
            tick     = (m_presc == TICK_DIV - 1);
            m_presc  = tick ? 0 : m_presc + 1;
            pop      = 0;
            n_before = mq.size();
            ea = player_a_keys & ~m_kpa;
            eb = player_b_keys & ~m_kpb;
            if (n_before > 0) begin
                inwin = (mq[0].age >= TRAVEL - WINDOW) && (mq[0].age <= TRAVEL + WINDOW);
                if (mq[0].ad && mq[0].bd) begin
                    pop = 1;
                end else if (mq[0].age == EXPIRE) begin
                    pop = 1;
                    e_ma = !mq[0].ad;
                    e_mb = !mq[0].bd;
                end else begin
                    if (ea != 0 && (ea & ~mq[0].mask) == 0 && (ea & mq[0].mask) != 0 && !mq[0].ad && inwin) begin
                        e_ha = 1;
                        mq[0].ad = 1;
                    end
                    if (eb != 0 && (eb & ~mq[0].mask) == 0 && (eb & mq[0].mask) != 0 && !mq[0].bd && inwin) begin
                        e_hb = 1;
                        mq[0].bd = 1;
                    end
                end
            end
            if (tick) begin
                foreach (mq[i]) begin
                    if (mq[i].age < EXPIRE) mq[i].age = mq[i].age + 1;
                end
            end
            if (pop) mq.delete(0);
            if (pattern_valid && pattern_out[3:0] != 4'h0) begin
                if (n_before < DEPTH || pop) begin
                    na.mask = pattern_out[3:0];
                    na.age  = 0;
                    na.ad   = 0;
                    na.bd   = 0;
                    mq.push_back(na);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        m_kpa = player_a_keys;
        m_kpb = player_b_keys;
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        if (resetn) model_step(); else model_reset();
        #1;
        chk("m_hit_a", perfect_hit_a, e_ha);
        chk("m_hit_b", perfect_hit_b, e_hb);
        chk("m_miss_a", miss_a, e_ma);
        chk("m_miss_b", miss_b, e_mb);
        chk("m_count", queue_count, mq.size());
        chk("m_overflow", overflow, m_ovf);
    endtask

    task automatic push(input logic [7:0] m);
        pattern_valid = 1'b1;
        pattern_out   = m;
        cyc();
        pattern_valid = 1'b0;
    endtask

    task automatic wait_age(input int a);
        int n = 0;
        while (!(mq.size() > 0 && mq[0].age == a) && n < 200) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $error("FAIL wait_age observed=timeout expected=age %0d", a);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (mq.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $error("FAIL wait_empty observed=timeout expected=empty queue");
        end
    endtask

    // Called just after an active edge; asserts reset between edges.
    task automatic async_reset();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_hit_a", perfect_hit_a, 0);
        chk("rst_hit_b", perfect_hit_b, 0);
        chk("rst_miss_a", miss_a, 0);
        chk("rst_miss_b", miss_b, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_overflow", overflow, 0);
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    initial begin
        int misses;
        model_reset();
        cyc();
        cyc();
        chk("init_count", queue_count, 0);
        chk("init_overflow", overflow, 0);
        chk("init_hit_a", perfect_hit_a, 0);
        resetn = 1'b1;
        game_active = 1'b1;
        cyc();

        // Reset mid-stream with three arrows queued
        push(8'h01);
        push(8'h02);
        push(8'h04);
        chk("s1_count3", queue_count, 3);
        async_reset();
        push(8'hF1);
        chk("s1_count_after", queue_count, 1);

        // Hit by A at age 10, B expires
        wait_age(10);
        player_a_keys = 4'b0001;
        cyc();
        chk("s2_hit_a", perfect_hit_a, 1);
        player_a_keys = 4'b0000;
        cyc();
        chk("s2_hit_a_width", perfect_hit_a, 0);
        wait_age(EXPIRE);
        cyc();
        chk("s2_miss_b", miss_b, 1);
        chk("s2_no_miss_a", miss_a, 0);
        chk("s2_count0", queue_count, 0);
        cyc();
        chk("s2_miss_b_width", miss_b, 0);

        // Window lower edge
        push(8'h01);
        wait_age(7);
        player_a_keys = 4'b0001;
        cyc();
        chk("s3_age7_nohit", perfect_hit_a, 0);
        player_a_keys = 4'b0000;
        cyc();
        wait_age(8);
        player_a_keys = 4'b0001;
        cyc();
        chk("s3_age8_hit", perfect_hit_a, 1);
        player_a_keys = 4'b0000;
        wait_empty();

        // Window upper edge
        push(8'h01);
        wait_age(12);
        player_a_keys = 4'b0001;
        cyc();
        chk("s3_age12_hit", perfect_hit_a, 1);
        player_a_keys = 4'b0000;
        wait_empty();

        push(8'h01);
        wait_age(EXPIRE);
        player_a_keys = 4'b0001;
        cyc();
        chk("s3_age13_nohit", perfect_hit_a, 0);
        chk("s3_age13_miss_a", miss_a, 1);
        chk("s3_age13_count", queue_count, 0);
        player_a_keys = 4'b0000;
        cyc();

        // Lane rules on mask 0011
        push(8'h03);
        wait_age(10);
        player_a_keys = 4'b0010;
        player_b_keys = 4'b1001;
        cyc();
        chk("s4_a_down_hit", perfect_hit_a, 1);
        chk("s4_b_wrong_nohit", perfect_hit_b, 0);
        player_a_keys = 4'b0000;
        player_b_keys = 4'b0000;
        wait_age(EXPIRE);
        cyc();
        chk("s4_miss_b", miss_b, 1);
        chk("s4_no_miss_a", miss_a, 0);

        push(8'h03);
        wait_age(9);
        player_a_keys = 4'b0001;
        cyc();
        chk("s4_both_hit_a", perfect_hit_a, 1);
        player_a_keys = 4'b0000;
        cyc();
        player_b_keys = 4'b0010;
        cyc();
        chk("s4_both_hit_b", perfect_hit_b, 1);
        chk("s4_count_n1", queue_count, 1);
        player_b_keys = 4'b0000;
        cyc();
        chk("s4_count_n2", queue_count, 0);
        chk("s4_no_miss", miss_a | miss_b, 0);

        // Overflow with five back-to-back arrows
        pattern_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pattern_out = 8'(i + 1);
            cyc();
            if (i == 3) begin
                chk("s5_count4", queue_count, 4);
                chk("s5_no_ovf_yet", overflow, 0);
            end
        end
        chk("s5_count_full", queue_count, 4);
        chk("s5_overflow", overflow, 1);
        pattern_valid = 1'b0;
        misses = 0;
        for (int k = 0; k < 80; k++) begin
            cyc();
            misses += int'(miss_a);
        end
        chk("s5_four_misses", misses, 4);
        chk("s5_drained", queue_count, 0);
        chk("s5_ovf_sticky", overflow, 1);

        // Pause: frozen ages, ignored push, held key gives no edge
        push(8'h01);
        wait_age(5);
        game_active = 1'b0;
        for (int k = 0; k < 200; k++) begin
            pattern_valid = (k == 50);
            pattern_out   = 8'h02;
            if (k == 100) player_a_keys = 4'b0001;
            cyc();
        end
        pattern_valid = 1'b0;
        chk("s6_pause_count", queue_count, 1);
        game_active = 1'b1;
        cyc();
        chk("s6_resume_no_edge", perfect_hit_a, 0);
        chk("s6_resume_count", queue_count, 1);
        wait_age(10);
        cyc();
        chk("s6_held_nohit", perfect_hit_a, 0);
        player_a_keys = 4'b0000;
        cyc();
        player_a_keys = 4'b0001;
        cyc();
        chk("s6_fresh_hit", perfect_hit_a, 1);
        player_a_keys = 4'b0000;
        wait_empty();

        // Random traffic against the model
        async_reset();
        for (int k = 0; k < 3000; k++) begin
            game_active   = ($urandom_range(0, 19) != 0);
            pattern_valid = ($urandom_range(0, 7) == 0);
            pattern_out   = 8'($urandom);
            if ($urandom_range(0, 5) == 0) player_a_keys = 4'($urandom);
            if ($urandom_range(0, 5) == 0) player_b_keys = 4'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
